// File: rtl/gpc31_3_pipe.sv
// gpc31_3_pipe: registered (3,1;3) parallel counter, dst = src0 + 2*popcount(src1)
// with a valid flag travelling alongside the data.
module gpc31_3_pipe (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic       src0,
   input  logic [2:0] src1,
   output logic [2:0] dst,
   output logic       out_valid
);
   logic [2:0] sum;
   // Popcount of the weight-2 column: XOR3 gives the low bit, MAJ3 the carry.
   always_comb sum = {(src1[0] & src1[1]) | (src1[0] & src1[2]) | (src1[1] & src1[2]),
                      ^src1, src0};
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         dst       <= 3'b000;
         out_valid <= 1'b0;
      end else begin
         dst       <= sum;
         out_valid <= in_valid;
      end
endmodule

// File: tb/tb_gpc31_3_pipe.sv
// tb_gpc31_3_pipe: per-cycle comparison against an arithmetic model, plus
// directed literal checks for the exhaustive, weight, valid and reset cases.
module tb_gpc31_3_pipe;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       src0 = 1'b0;
   logic [2:0] src1 = 3'b000;
   logic [2:0] dst;
   logic       out_valid;
   int         n_cmp = 0;
   int         n_fail = 0;
   int         m_dst = 0;
   int         m_v = 0;

   gpc31_3_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .src0(src0), .src1(src1),
      .dst(dst), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int gpc(input logic [3:0] v);
      return int'(v[0]) + 2 * (int'(v[1]) + int'(v[2]) + int'(v[3]));
   endfunction

   // Model: the value the output register must hold after each edge.
   always @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         m_dst = 0;
         m_v   = 0;
      end else begin
         m_dst = gpc({src1, src0});
         m_v   = int'(in_valid);
      end

   always @(negedge clk) begin
      check("model_dst", int'(dst), m_dst);
      check("model_valid", int'(out_valid), m_v);
   end

   task automatic apply(input logic [3:0] v, input logic iv);
      @(negedge clk);
      #2;
      {src1, src0} = v;
      in_valid     = iv;
   endtask

   task automatic expect_after(input string nm, input int d, input int ov);
      @(posedge clk);
      #1;
      check({nm, "_dst"}, int'(dst), d);
      check({nm, "_valid"}, int'(out_valid), ov);
   endtask

   initial begin
      #3;
      check("reset_dst", int'(dst), 0);
      check("reset_valid", int'(out_valid), 0);
      {src1, src0} = 4'hf;
      in_valid     = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("held_reset_dst", int'(dst), 0);
      check("held_reset_valid", int'(out_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      // Exhaustive sweep, pinned against literal samples where listed.
      for (int v = 0; v < 16; v++) begin
         apply(4'(v), 1'b1);
         expect_after("exh", gpc(4'(v)), 1);
      end
      apply(4'h0, 1'b1); expect_after("lit_0", 0, 1);
      apply(4'h1, 1'b1); expect_after("lit_1", 1, 1);
      apply(4'h2, 1'b1); expect_after("lit_2", 2, 1);
      apply(4'h7, 1'b1); expect_after("lit_7", 5, 1);
      apply(4'he, 1'b1); expect_after("lit_e", 6, 1);
      apply(4'hf, 1'b1); expect_after("max", 7, 1);
      apply({3'b001, 1'b0}, 1'b1); expect_after("w001", 2, 1);
      apply({3'b010, 1'b0}, 1'b1); expect_after("w010", 2, 1);
      apply({3'b100, 1'b0}, 1'b1); expect_after("w100", 2, 1);
      apply({3'b011, 1'b0}, 1'b1); expect_after("w011", 4, 1);
      apply(4'h5, 1'b1); expect_after("vt5", 3, 1);
      apply(4'h3, 1'b0); expect_after("vt3", 3, 0);
      apply(4'h9, 1'b1); expect_after("vt9", 3, 1);
      // Asynchronous reset between edges while dst = 7.
      apply(4'hf, 1'b1); expect_after("pre_rst", 7, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_dst", int'(dst), 0);
      check("async_valid", int'(out_valid), 0);
      apply(4'hb, 1'b1);
      rst_n = 1'b1;
      expect_after("release_b", 5, 1);
      // Random stream, checked every cycle by the model comparison.
      for (int i = 0; i < 400; i++) begin
         apply(4'($urandom_range(15)), 1'($urandom_range(1)));
         if (i == 200) begin
            #1;
            rst_n = 1'b0;
            #1;
            check("mid_rst_dst", int'(dst), 0);
            rst_n = 1'b1;
         end
      end
      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
